// File: rtl/ram_burst_ctrl.sv
// Burst command front-end for a 256x32 synchronous RAM: turns cmd/wdata/rdata
// streams into raw address, write-enable and data signals.
module ram_burst_ctrl #(
  parameter int STRIDE = 4,
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wr,
  input  logic [7:0]  cmd_addr,
  input  logic [3:0]  cmd_len,
  input  logic        wdata_valid,
  output logic        wdata_ready,
  input  logic [31:0] wdata,
  output logic        rdata_valid,
  input  logic        rdata_ready,
  output logic [31:0] rdata,
  output logic        rdata_last,
  output logic        busy,
  output logic [7:0]  mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_do,
  output logic [2:0]  dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1; valid and its payload stay stable until that edge, and ready
  // never depends on valid.

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    RD_ADDR = 3'd2,
    RD_WAIT = 3'd3,
    RD_RESP = 3'd4
  } state_t;

  localparam logic [7:0] STEP      = 8'(STRIDE);
  localparam logic [1:0] WAIT_INIT = 2'((RD_LAT > 0) ? RD_LAT - 1 : 0);

  state_t      state_q, state_d;
  logic [7:0]  addr_q, addr_d;
  logic [3:0]  rem_q, rem_d;
  logic [1:0]  wait_q, wait_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;
  logic        rlast_q, rlast_d;
  logic        cmd_ready_c, wdata_ready_c, mem_wr_c;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    rem_d         = rem_q;
    wait_d        = wait_q;
    rdata_d       = rdata_q;
    rvalid_d      = rvalid_q;
    rlast_d       = rlast_q;
    cmd_ready_c   = 1'b0;
    wdata_ready_c = 1'b0;
    mem_wr_c      = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready_c = 1'b1;
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          rem_d   = cmd_len;
          state_d = cmd_wr ? WRITE : RD_ADDR;
        end
      end
      WRITE: begin
        wdata_ready_c = 1'b1;
        mem_wr_c      = wdata_valid;
        if (wdata_valid) begin
          addr_d = addr_q + STEP;
          if (rem_q == 4'd0) state_d = IDLE;
          else               rem_d   = rem_q - 4'd1;
        end
      end
      RD_ADDR: begin
        // With a zero-latency RAM the data is already valid during this cycle.
        if (RD_LAT == 0) begin
          rdata_d  = mem_do;
          rvalid_d = 1'b1;
          rlast_d  = (rem_q == 4'd0);
          state_d  = RD_RESP;
        end else begin
          wait_d  = WAIT_INIT;
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (wait_q == 2'd0) begin
          rdata_d  = mem_do;
          rvalid_d = 1'b1;
          rlast_d  = (rem_q == 4'd0);
          state_d  = RD_RESP;
        end else begin
          wait_d = wait_q - 2'd1;
        end
      end
      RD_RESP: begin
        if (rdata_ready) begin
          rvalid_d = 1'b0;
          if (rlast_q) begin
            state_d = IDLE;
          end else begin
            addr_d  = addr_q + STEP;
            rem_d   = rem_q - 4'd1;
            state_d = RD_ADDR;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= 8'd0;
      rem_q    <= 4'd0;
      wait_q   <= 2'd0;
      rdata_q  <= 32'd0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      wait_q   <= wait_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      rlast_q  <= rlast_d;
    end
  end

  // Handshake outputs are masked by rst so nothing transfers in a reset cycle.
  assign cmd_ready   = cmd_ready_c & ~rst;
  assign wdata_ready = wdata_ready_c & ~rst;
  assign mem_wr      = mem_wr_c & ~rst;
  assign rdata_valid = rvalid_q & ~rst;
  assign busy        = (state_q != IDLE) & ~rst;
  assign rdata       = rdata_q;
  assign rdata_last  = rlast_q;
  assign mem_addr    = addr_q;
  assign mem_din     = wdata;
  assign dbg_state   = state_q;

endmodule
